// File: rtl/sdram_avalon_arbiter.sv
// sdram_avalon_arbiter
//   Shares the SDRAM controller's single Avalon-MM slave between two fabric
//   masters (m0, m1). Commands are serialised onto the d_* port. A small
//   owner FIFO tracks outstanding pipelined reads so that each
//   d_readdatavalid beat is routed back to the master that issued the read.
//
// Ports
//   clk_clk, reset_reset_n      : clock, asynchronous active-low reset
//   mN_address/read/write/
//   mN_writedata/byteenable     : master N command (N = 0, 1)
//   mN_waitrequest              : master N stall
//   mN_readdata                 : read data, broadcast to both masters
//   mN_readdatavalid            : read beat belongs to master N
//   d_address/read/write/
//   d_writedata/byteenable      : command to the SDRAM controller
//   d_waitrequest/readdata/
//   d_readdatavalid             : response from the SDRAM controller
//   pend_err                    : sticky, a read beat arrived with no owner
//
// Build option
//   SDRAM_ARB_FIXED_PRIO_EN : when defined, m0 always wins contention
//   (m1 may starve). When undefined, arbitration is round-robin.

module sdram_avalon_arbiter #(
    parameter int AW    = 25,
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic            clk_clk,
    input  logic            reset_reset_n,

    input  logic [AW-1:0]   m0_address,
    input  logic            m0_read,
    input  logic            m0_write,
    input  logic [DW-1:0]   m0_writedata,
    input  logic [DW/8-1:0] m0_byteenable,
    output logic            m0_waitrequest,
    output logic [DW-1:0]   m0_readdata,
    output logic            m0_readdatavalid,

    input  logic [AW-1:0]   m1_address,
    input  logic            m1_read,
    input  logic            m1_write,
    input  logic [DW-1:0]   m1_writedata,
    input  logic [DW/8-1:0] m1_byteenable,
    output logic            m1_waitrequest,
    output logic [DW-1:0]   m1_readdata,
    output logic            m1_readdatavalid,

    output logic [AW-1:0]   d_address,
    output logic            d_read,
    output logic            d_write,
    output logic [DW-1:0]   d_writedata,
    output logic [DW/8-1:0] d_byteenable,
    input  logic            d_waitrequest,
    input  logic [DW-1:0]   d_readdata,
    input  logic            d_readdatavalid,

    output logic            pend_err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, G0, G1} state_t;

    state_t state, state_nxt;

    logic [DEPTH-1:0] own;      // owner of each outstanding read (1 = m1)
    logic [PW-1:0]    wptr, rptr;
    logic [PW:0]      count;

    logic req0, req1, granted, sel1;
    logic cmd_read, cmd_write;
    logic full, empty, acc, push, pop, head;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
`else
    logic last, last_nxt;       // most recently accepted master (1 = m1)
`endif

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    assign granted   = (state != IDLE);
    assign sel1      = (state == G1);
    assign cmd_read  = sel1 ? m1_read  : m0_read;
    assign cmd_write = sel1 ? m1_write : m0_write;

    // Full comes from the registered count only: a pop this cycle does not
    // free a slot for a push this cycle.
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Command pass-through; a read that would overflow the FIFO is hidden
    // from the controller until a slot frees up.
    assign d_address    = sel1 ? m1_address    : m0_address;
    assign d_writedata  = sel1 ? m1_writedata  : m0_writedata;
    assign d_byteenable = sel1 ? m1_byteenable : m0_byteenable;
    assign d_read       = granted & cmd_read & ~full;
    assign d_write      = granted & cmd_write;

    assign acc  = granted & (cmd_read | cmd_write) & ~d_waitrequest
                & ~(cmd_read & full);
    assign push = acc & cmd_read;
    assign pop  = d_readdatavalid & ~empty;
    assign head = own[rptr];

    assign m0_waitrequest   = ~(acc & (state == G0));
    assign m1_waitrequest   = ~(acc & sel1);
    assign m0_readdata      = d_readdata;
    assign m1_readdata      = d_readdata;
    assign m0_readdatavalid = pop & ~head;
    assign m1_readdatavalid = pop & head;

    // Next-state / arbitration
    always_comb begin
        state_nxt = state;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        unique case (state)
            IDLE: begin
                if (req0)      state_nxt = G0;
                else if (req1) state_nxt = G1;
            end
            G0: begin
                // Re-arbitrate through IDLE so m0 keeps winning.
                if (acc || !req0) state_nxt = IDLE;
            end
            G1: begin
                if (acc)       state_nxt = req0 ? G0 : IDLE;
                else if (!req1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
`else
        last_nxt = last;
        unique case (state)
            IDLE: begin
                if (req0 && req1) state_nxt = last ? G0 : G1;
                else if (req0)    state_nxt = G0;
                else if (req1)    state_nxt = G1;
            end
            G0: begin
                if (acc) begin
                    last_nxt  = 1'b0;
                    state_nxt = req1 ? G1 : IDLE;
                end else if (!req0) begin
                    state_nxt = IDLE;
                end
            end
            G1: begin
                if (acc) begin
                    last_nxt  = 1'b1;
                    state_nxt = req0 ? G0 : IDLE;
                end else if (!req1) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
`endif
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
`else
            last  <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
`else
            last  <= last_nxt;
`endif
        end
    end

    // Owner FIFO
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            own      <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            pend_err <= 1'b0;
        end else begin
            if (push) begin
                own[wptr] <= sel1;
                wptr      <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (d_readdatavalid && empty)
                pend_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_avalon_arbiter.sv
// Self-checking bench for sdram_avalon_arbiter: directed scenarios followed
// by randomized traffic checked against a transaction-level model.
module tb_sdram_avalon_arbiter;

    localparam int AW = 25;
    localparam int DW = 16;

    logic          clk_clk = 1'b0;
    logic          reset_reset_n;
    logic [AW-1:0] m0_address, m1_address, d_address;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0] m0_writedata, m1_writedata, d_writedata;
    logic [1:0]    m0_byteenable, m1_byteenable, d_byteenable;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata, d_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic          d_read, d_write, d_waitrequest, d_readdatavalid;
    logic          pend_err;

    int n_vec = 0;
    int n_err = 0;

    always #10 clk_clk = ~clk_clk;

    sdram_avalon_arbiter #(.AW(AW), .DW(DW), .DEPTH(8)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
        .d_readdatavalid(d_readdatavalid),
        .pend_err(pend_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Data the slave model returns for a read of address a.
    function automatic logic [15:0] rd_val(input logic [AW-1:0] a);
        return a[15:0] ^ 16'h5A3C;
    endfunction

    task automatic idle_inputs();
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = 2'b11;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = 2'b11;
        d_waitrequest = 0; d_readdata = '0; d_readdatavalid = 0;
    endtask

    // Leaves the caller 1 time unit after a rising edge (the drive point).
    task automatic do_reset();
        idle_inputs();
        reset_reset_n = 0;
        repeat (2) @(posedge clk_clk);
        #1 reset_reset_n = 1;
    endtask

    task automatic next_cycle();
        @(posedge clk_clk);
        #1;
    endtask

    // Randomized-phase model state
    bit            pend[2];
    bit            mr[2];
    logic [AW-1:0] ma[2];
    logic [DW-1:0] mwd[2];
    logic [1:0]    mbe[2];
    int            age[2];
    int            own_q[$];
    logic [15:0]   exp_q0[$], exp_q1[$];
    logic [AW-1:0] slv_a[$];
    int            slv_t[$];

    task automatic apply_masters();
        m0_address = ma[0]; m0_read = pend[0] & mr[0]; m0_write = pend[0] & ~mr[0];
        m0_writedata = mwd[0]; m0_byteenable = mbe[0];
        m1_address = ma[1]; m1_read = pend[1] & mr[1]; m1_write = pend[1] & ~mr[1];
        m1_writedata = mwd[1]; m1_byteenable = mbe[1];
    endtask

    initial begin
        int acc_n, guard, owed, n;
        bit seen, a0, a1, ad, other_req, timed_out;
        logic [1:0] exp_acc;
        logic [63:0] got_cmd, exp_cmd;
        logic [15:0] exp_d;

        // ---------------- reset state ----------------
        do_reset();
        @(negedge clk_clk);
        chk("rst_dread",  64'(d_read), 64'(0));
        chk("rst_dwrite", 64'(d_write), 64'(0));
        chk("rst_wait",   64'({m1_waitrequest, m0_waitrequest}), 64'(2'b11));
        chk("rst_rdv",    64'({m1_readdatavalid, m0_readdatavalid}), 64'(0));
        chk("rst_perr",   64'(pend_err), 64'(0));
        next_cycle();

        // ---------------- single read ----------------
        m0_read = 1; m0_address = 25'h100;
        @(negedge clk_clk);
        chk("sr_idle_dread", 64'(d_read), 64'(0));
        chk("sr_idle_wait",  64'(m0_waitrequest), 64'(1));
        next_cycle();
        @(negedge clk_clk);
        chk("sr_dread", 64'(d_read), 64'(1));
        chk("sr_addr",  64'(d_address), 64'(25'h100));
        chk("sr_acc",   64'(m0_waitrequest), 64'(0));
        next_cycle();
        m0_read = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_clk);
            chk("sr_norv", 64'({m1_readdatavalid, m0_readdatavalid}), 64'(0));
            next_cycle();
        end
        d_readdatavalid = 1; d_readdata = 16'hBEEF;
        @(negedge clk_clk);
        chk("sr_rdv0",  64'(m0_readdatavalid), 64'(1));
        chk("sr_data",  64'(m0_readdata), 64'(16'hBEEF));
        chk("sr_rdv1",  64'(m1_readdatavalid), 64'(0));
        next_cycle();
        d_readdatavalid = 0;

        // ---------------- contention, round-robin from reset ----------------
        do_reset();
        m0_write = 1; m0_address = 25'h10; m1_write = 1; m1_address = 25'h20;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_clk);
            exp_acc = (k == 0) ? 2'b00 : ((k % 2) ? 2'b01 : 2'b10);
            chk("rr_order_dir", 64'({~m1_waitrequest, ~m0_waitrequest}), 64'(exp_acc));
            next_cycle();
        end

        // ---------------- interleaved reads ----------------
        do_reset();
        m0_read = 1; m0_address = 25'hA; m1_read = 1; m1_address = 25'hB;
        @(negedge clk_clk);
        chk("il_none", 64'({~m1_waitrequest, ~m0_waitrequest}), 64'(0));
        next_cycle();
        @(negedge clk_clk);
        chk("il_acc_a", 64'({~m1_waitrequest, ~m0_waitrequest}), 64'(2'b01));
        next_cycle();
        m0_address = 25'hC;
        @(negedge clk_clk);
        chk("il_acc_b", 64'({~m1_waitrequest, ~m0_waitrequest}), 64'(2'b10));
        next_cycle();
        m1_read = 0;
        @(negedge clk_clk);
        chk("il_acc_c", 64'({~m1_waitrequest, ~m0_waitrequest}), 64'(2'b01));
        chk("il_addr_c", 64'(d_address), 64'(25'hC));
        next_cycle();
        m0_read = 0;
        for (int i = 0; i < 3; i++) begin
            d_readdatavalid = 1; d_readdata = 16'(i + 1);
            @(negedge clk_clk);
            chk("il_route", 64'({m1_readdatavalid, m0_readdatavalid}), 64'((i == 1) ? 2 : 1));
            chk("il_data", 64'(m0_readdata), 64'(i + 1));
            next_cycle();
        end
        // FIFO must be empty again: a further beat is an orphan.
        d_readdatavalid = 1;
        @(negedge clk_clk);
        chk("err_rdv", 64'({m1_readdatavalid, m0_readdatavalid}), 64'(0));
        next_cycle();
        d_readdatavalid = 0;
        @(negedge clk_clk);
        chk("err_flag", 64'(pend_err), 64'(1));
        next_cycle();

        // ---------------- reset while G1 holds a stalled read ----------------
        d_waitrequest = 1; m1_read = 1; m1_address = 25'h33;
        @(negedge clk_clk);
        next_cycle();
        @(negedge clk_clk);
        chk("rs_dread_pre", 64'(d_read), 64'(1));
        chk("rs_stall",     64'(m1_waitrequest), 64'(1));
        chk("rs_perr_pre",  64'(pend_err), 64'(1));
        #2 reset_reset_n = 0;
        #1;
        chk("rs_dread",  64'(d_read), 64'(0));
        chk("rs_perr",   64'(pend_err), 64'(0));
        chk("rs_wait",   64'({m1_waitrequest, m0_waitrequest}), 64'(2'b11));
        idle_inputs();
        next_cycle();
        reset_reset_n = 1;

        // ---------------- FIFO full ----------------
        do_reset();
        m0_read = 1;
        acc_n = 0; guard = 0;
        while (acc_n < 8 && guard < 40) begin
            @(negedge clk_clk);
            if (!m0_waitrequest) acc_n++;
            next_cycle();
            m0_address = 25'(acc_n);
            guard++;
        end
        chk("ff_acc8", 64'(acc_n), 64'(8));
        m0_read = 0; m1_write = 1; m1_address = 25'h55;
        seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk_clk);
            if (!m1_waitrequest) seen = 1;
            next_cycle();
        end
        chk("ff_wr_ok", 64'(seen), 64'(1));
        m1_write = 0; m0_read = 1; m0_address = 25'h99;
        @(negedge clk_clk);
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_clk);
            chk("ff_block_wait",  64'(m0_waitrequest), 64'(1));
            chk("ff_block_dread", 64'(d_read), 64'(0));
            next_cycle();
        end
        d_readdatavalid = 1; d_readdata = 16'h1234;
        @(negedge clk_clk);
        chk("ff_pop_wait", 64'(m0_waitrequest), 64'(1));
        chk("ff_pop_rdv",  64'(m0_readdatavalid), 64'(1));
        next_cycle();
        d_readdatavalid = 0;
        @(negedge clk_clk);
        chk("ff_unblock_wait",  64'(m0_waitrequest), 64'(0));
        chk("ff_unblock_dread", 64'(d_read), 64'(1));
        next_cycle();
        m0_read = 0;

        // ---------------- randomized traffic ----------------
        do_reset();
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; mr[i] = 0; ma[i] = '0; mwd[i] = '0; mbe[i] = 2'b11; age[i] = 0;
        end
        apply_masters();
        owed = -1;
        timed_out = 0;
        for (int cyc = 0; cyc < 2600; cyc++) begin
            @(negedge clk_clk);
            a0 = (m0_read | m0_write) & ~m0_waitrequest;
            a1 = (m1_read | m1_write) & ~m1_waitrequest;
            ad = (d_read | d_write) & ~d_waitrequest;
            chk("acc_cnt", 64'(int'(a0) + int'(a1)), 64'(ad));
            if (a0 || a1) begin
                n = a1 ? 1 : 0;
                got_cmd = 64'({d_address, d_read, d_write, d_writedata, d_byteenable});
                exp_cmd = n ? 64'({m1_address, m1_read, m1_write, m1_writedata, m1_byteenable})
                            : 64'({m0_address, m0_read, m0_write, m0_writedata, m0_byteenable});
                chk("cmd", got_cmd, exp_cmd);
                if (owed >= 0) chk("rr_order", 64'(n), 64'(owed));
                other_req = n ? (m0_read | m0_write) : (m1_read | m1_write);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
                owed = (n == 1 && other_req) ? 0 : -1;
`else
                owed = other_req ? 1 - n : -1;
`endif
                if (mr[n]) begin
                    own_q.push_back(n);
                    if (n == 0) exp_q0.push_back(rd_val(ma[0]));
                    else        exp_q1.push_back(rd_val(ma[1]));
                    slv_a.push_back(d_address);
                    slv_t.push_back(cyc + int'($urandom_range(2, 5)));
                end
                pend[n] = 0;
            end
            if (d_readdatavalid && own_q.size() > 0) begin
                n = own_q.pop_front();
                chk("rdv_route", 64'({m1_readdatavalid, m0_readdatavalid}), 64'(n ? 2 : 1));
                exp_d = n ? exp_q1.pop_front() : exp_q0.pop_front();
                chk("rdata", 64'(n ? m1_readdata : m0_readdata), 64'(exp_d));
            end else begin
                chk("rdv_quiet", 64'({m1_readdatavalid, m0_readdatavalid}), 64'(0));
            end
            for (int i = 0; i < 2; i++) begin
                age[i] = pend[i] ? age[i] + 1 : 0;
                if (age[i] > 300) timed_out = 1;
            end
            if (timed_out) begin
                chk("timeout", 64'(1), 64'(0));
                break;
            end
            next_cycle();
            // New master commands (none in the final drain window)
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && cyc < 2200 && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    mr[i]   = 1'($urandom_range(0, 1));
                    ma[i]   = 25'($urandom);
                    mwd[i]  = 16'($urandom);
                    mbe[i]  = 2'($urandom_range(1, 3));
                end
            end
            apply_masters();
            d_waitrequest = ($urandom_range(0, 3) == 0);
            if (slv_a.size() > 0 && slv_t[0] <= cyc && $urandom_range(0, 1) == 1) begin
                d_readdatavalid = 1;
                d_readdata = rd_val(slv_a.pop_front());
                void'(slv_t.pop_front());
            end else begin
                d_readdatavalid = 0;
                d_readdata = 16'($urandom);
            end
        end
        chk("drain", 64'(own_q.size() + slv_a.size()), 64'(0));
        chk("rand_perr", 64'(pend_err), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
